inc16_arbiter: RTL and testbench

INC16_ARBITER -- requirements
Module: inc16_arbiter

---
 rtl/inc16_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_inc16_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inc16_arbiter.sv
// rtl/inc16_arbiter.sv - four-requester arbiter sharing one ripple incrementer
//
// Purpose:
//   Arbitrates among four requesters. The winner's operand is incremented by
//   one through a single shared W-bit ripple incrementer, and the result is
//   returned with the owner's index. Handling is strictly one operation at a
//   time, using the states IDLE -> EXEC -> RESP.
//
// Configuration:
//   INC_ARB_ROUND_ROBIN_EN  defined   : round-robin arbitration. The search
//                                       starts at pointer P. On response
//                                       completion, P becomes rsp_id + 1.
//                           undefined : fixed priority, requester 0 highest.
//                                       No pointer state exists.
//
// Ports:
//   clk        in   clock; all state updates happen on the rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [3:0]     per-requester operand valid
//   req_data   in   [4*W-1:0] packed operands; requester i at [i*W +: W]
//   req_ready  out  [3:0]     one-hot grant; asserted only in IDLE
//   rsp_valid  out            result valid
//   rsp_data   out  [W-1:0]   operand + 1, modulo 2^W
//   rsp_id     out  [1:0]     index of the requester that owns rsp_data
//   rsp_carry  out            operand was all-ones
//   rsp_ready  in             consumer accepts the result
//   busy       out            FSM is not in IDLE

module inc16_arbiter #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req_valid,
  input  logic [4*W-1:0] req_data,
  output logic [3:0]     req_ready,
  output logic           rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic [1:0]     rsp_id,
  output logic           rsp_carry,
  input  logic           rsp_ready,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic         grant_any;
  logic [1:0]   grant_idx;
  logic [3:0]   grant_oh;
  logic [W-1:0] grant_op;
  logic         accept;

  logic [W-1:0] op_q;
  logic [1:0]   id_q;

  logic [W:0]   chain;
  logic [W-1:0] inc_sum;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
`ifdef INC_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr;

  // The walk runs from the farthest candidate back to the pointer, so the
  // candidate closest to ptr is written last and therefore wins.
  always_comb begin
    logic [1:0] cand;
    grant_any = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else if (state == RESP && rsp_valid && rsp_ready) begin
      ptr <= rsp_id + 2'd1;
    end
  end
`else
  always_comb begin
    grant_any = |req_valid;
    grant_idx = 2'd0;
    if (req_valid[0])      grant_idx = 2'd0;
    else if (req_valid[1]) grant_idx = 2'd1;
    else if (req_valid[2]) grant_idx = 2'd2;
    else if (req_valid[3]) grant_idx = 2'd3;
  end
`endif

  assign grant_oh = grant_any ? (4'b0001 << grant_idx) : 4'b0000;

  // Gating on rst_n keeps req_ready low throughout reset. It also means the
  // first accept can only land on an edge where rst_n is already high.
  assign accept = (state == IDLE) && rst_n && grant_any;

  always_comb begin
    grant_op = req_data[0 +: W];
    case (grant_idx)
      2'd0: grant_op = req_data[0*W +: W];
      2'd1: grant_op = req_data[1*W +: W];
      2'd2: grant_op = req_data[2*W +: W];
      2'd3: grant_op = req_data[3*W +: W];
      default: grant_op = req_data[0 +: W];
    endcase
  end

  // ---------------------------------------------------------------------
  // Shared ripple incrementer: each bit's carry-in is the AND of all lower
  // operand bits.
  // ---------------------------------------------------------------------
  assign chain[0] = 1'b1;
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_ripple
      assign chain[gi+1] = op_q[gi] & chain[gi];
    end
  endgenerate
  assign inc_sum = op_q ^ chain[W-1:0];

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 4'b0000;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rst_n ? grant_oh : 4'b0000;
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        busy       = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        busy = 1'b1;
        // req_ready stays low here, so completion and a new accept never
        // share a cycle.
        if (rsp_valid && rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      id_q      <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 2'd0;
      rsp_carry <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= grant_op;
        id_q <= grant_idx;
      end
      if (state == EXEC) begin
        rsp_data  <= inc_sum;
        rsp_carry <= chain[W];
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        // rsp_data, rsp_id and rsp_carry keep their last values.
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inc16_arbiter.sv
// tb/tb_inc16_arbiter.sv - directed self-checking bench for inc16_arbiter

module tb_inc16_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_carry;
  logic        rsp_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  inc16_arbiter #(.W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_carry (rsp_carry),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 64'h0004_0003_0002_0001;
    rsp_ready = 1'b1;
    tick();
    tick();
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++;
    if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h exp 0000", rsp_data); end
    checks++;
    if (rsp_id !== 2'd0 || rsp_carry !== 1'b0) begin errors++; $display("FAIL reset_id_carry got %0d/%b exp 0/0", rsp_id, rsp_carry); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    // Release mid-cycle with requesters 1 and 2 valid. The pointer is 0 after
    // reset, so both policies grant requester 1.
    req_valid = 4'b0110;
    rst_n = 1'b1;
    #1;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL prio_0110 got %b exp 0010", req_ready); end
    checks++;
    req_valid = 4'b0000;
    #1;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_no_req got %b exp 0000", req_ready); end
    checks++;
    tick();
    if (busy !== 1'b0) begin errors++; $display("FAIL no_accept_busy got %b exp 0", busy); end
    checks++;
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    req_data  = 64'hAAAA_BBBB_CCCC_1234;
    rsp_ready = 1'b1;
    #1;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    checks++;
    tick();
    req_valid = 4'b0000;
    req_data  = 64'h0;
    #1;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL single_exec got busy=%b valid=%b ready=%b exp 1/0/0000", busy, rsp_valid, req_ready);
    end
    checks++;
    tick();
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rsp_valid); end
    checks++;
    if (rsp_data !== 16'h1235) begin errors++; $display("FAIL single_data got %h exp 1235", rsp_data); end
    checks++;
    if (rsp_id !== 2'd0 || rsp_carry !== 1'b0) begin errors++; $display("FAIL single_id_carry got %0d/%b exp 0/0", rsp_id, rsp_carry); end
    checks++;
    tick();
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got valid=%b busy=%b exp 0/0", rsp_valid, busy); end
    checks++;
    if (rsp_data !== 16'h1235) begin errors++; $display("FAIL single_hold got %h exp 1235", rsp_data); end
    checks++;
  endtask

  task automatic test_wrap();
    req_valid = 4'b0100;
    req_data  = 64'h1111_FFFF_2222_3333;
    rsp_ready = 1'b1;
    #1;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ready got %b exp 0100", req_ready); end
    checks++;
    tick();
    req_valid = 4'b0000;
    tick();
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h0000) begin errors++; $display("FAIL wrap_data got valid=%b data=%h exp 1/0000", rsp_valid, rsp_data); end
    checks++;
    if (rsp_id !== 2'd2 || rsp_carry !== 1'b1) begin errors++; $display("FAIL wrap_id_carry got %0d/%b exp 2/1", rsp_id, rsp_carry); end
    checks++;
    tick();
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0010;
    req_data  = 64'h0000_0000_00FF_0000;
    rsp_ready = 1'b0;
    tick();
    // Every requester is valid while the response is held, yet none may be
    // granted.
    req_valid = 4'b1111;
    req_data  = 64'h0040_0030_0020_0010;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h0100 || rsp_id !== 2'd1 || rsp_carry !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got %b/%h/%0d/%b exp 1/0100/1/0", i, rsp_valid, rsp_data, rsp_id, rsp_carry);
      end
      checks++;
      if (req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_ready_busy[%0d] got %b/%b exp 0000/1", i, req_ready, busy);
      end
      checks++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_complete_cycle_ready got %b exp 0000", req_ready); end
    checks++;
    tick();
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_done got valid=%b busy=%b exp 0/0", rsp_valid, busy); end
    checks++;
`ifdef INC_ARB_ROUND_ROBIN_EN
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_next_ready got %b exp 0100", req_ready); end
`else
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_ready got %b exp 0001", req_ready); end
`endif
    checks++;
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_contention();
`ifdef INC_ARB_ROUND_ROBIN_EN
    int n = 5;
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    int n = 3;
    logic [1:0] exp_id [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    logic [15:0] exp_data;
    int waits;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    req_data  = 64'h0040_0030_0020_0010;
    rsp_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      waits = 0;
      while (rsp_valid !== 1'b1 && waits < 10) begin
        tick();
        waits++;
      end
      if (rsp_valid !== 1'b1) begin
        errors++; $display("FAIL cont_timeout[%0d] got valid=%b exp 1", k, rsp_valid);
      end
      checks++;
      exp_data = 16'h0011 + 16'h0010 * 16'(exp_id[k]);
      if (rsp_id !== exp_id[k] || rsp_data !== exp_data) begin
        errors++; $display("FAIL cont_rsp[%0d] got id=%0d data=%h exp id=%0d data=%h", k, rsp_id, rsp_data, exp_id[k], exp_data);
      end
      checks++;
      if (k > 0 && waits !== 2) begin
        errors++; $display("FAIL cont_spacing[%0d] got %0d exp 2", k, waits);
      end
      if (k > 0) checks++;
      tick();
    end
    req_valid = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_op();
    req_valid = 4'b1000;
    req_data  = 64'h5555_0000_0000_0000;
    rsp_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_exec_busy got %b exp 1", busy); end
    checks++;
    rst_n = 1'b0;
    #1;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_async got valid=%b busy=%b ready=%b exp 0/0/0000", rsp_valid, busy, req_ready);
    end
    checks++;
    if (rsp_data !== 16'h0000 || rsp_id !== 2'd0 || rsp_carry !== 1'b0) begin
      errors++; $display("FAIL mid_outputs got %h/%0d/%b exp 0000/0/0", rsp_data, rsp_id, rsp_carry);
    end
    checks++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL mid_no_rsp[%0d] got valid=%b busy=%b exp 0/0", i, rsp_valid, busy);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_contention();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
